// File: rtl/psr_flag_unit.sv
// Processor status register {C,L,F,Z,N} with compare/add/sub flag generation and a one-deep interrupt shadow.
// Latency: psr_fwd is combinational (same cycle), psr/psr_shadow are one cycle; en=0 stalls all state (no backpressure).
module psr_flag_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             psr_we,
    input  logic [4:0]       psr_wdata,
    input  logic             int_save,
    input  logic             int_restore,
    output logic [4:0]       psr,
    output logic [4:0]       psr_fwd,
    output logic [4:0]       psr_shadow,
    output logic             shadow_valid
);

    typedef struct packed {
        logic c;
        logic l;
        logic f;
        logic z;
        logic n;
    } psr_t;

    psr_t             psr_q;
    psr_t             shadow_q;
    psr_t             psr_nxt;
    logic             shadow_valid_q;
    logic             do_sub;
    logic [WIDTH:0]   res;
    logic             ovf_add;
    logic             ovf_sub;

    // One shared W+1 bit adder: CMP and SUB subtract, ADD adds; res[WIDTH] is carry or borrow.
    always_comb begin
        do_sub  = (op_sel != 2'b10);
        res     = do_sub ? ({1'b0, op_b} - {1'b0, op_a}) : ({1'b0, op_b} + {1'b0, op_a});
        ovf_add = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_b[WIDTH-1]);
        ovf_sub = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_b[WIDTH-1]);
    end

    always_comb begin
        psr_nxt = psr_q;
        if (en) begin
            if (int_restore) begin
                psr_nxt = shadow_q;
            end else if (psr_we) begin
                psr_nxt = psr_t'(psr_wdata);
            end else begin
                case (op_sel)
                    2'b01: begin
                        psr_nxt.z = (res[WIDTH-1:0] == '0);
                        psr_nxt.l = res[WIDTH];
                        // signed less-than: sign of the difference corrected by overflow
                        psr_nxt.n = res[WIDTH-1] ^ ovf_sub;
                    end
                    2'b10: begin
                        psr_nxt.c = res[WIDTH];
                        psr_nxt.f = ovf_add;
                    end
                    2'b11: begin
                        psr_nxt.c = res[WIDTH];
                        psr_nxt.f = ovf_sub;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q          <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else if (en) begin
            psr_q <= psr_nxt;
            // save captures the pre-update psr, so save+restore together swaps psr and shadow
            if (int_save) begin
                shadow_q       <= psr_q;
                shadow_valid_q <= 1'b1;
            end else if (int_restore) begin
                shadow_valid_q <= 1'b0;
            end
        end
    end

    assign psr          = psr_q;
    assign psr_fwd      = psr_nxt;
    assign psr_shadow   = shadow_q;
    assign shadow_valid = shadow_valid_q;

endmodule
